// File: rtl/elevador_pkg.sv
// elevador_pkg: shared types and defaults for the elevador request scheduler.
package elevador_pkg;

  // Floor indices are always carried on this many bits (up to 8 floors).
  localparam int FLOOR_W = 3;

  // Default build-time configuration.
  localparam int N_ANDARES_DEF   = 5;
  localparam int DOOR_CYCLES_DEF = 8;

  // Scheduler states: idle, travelling up, travelling down, door open.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOBE  = 2'd1,
    DESCE = 2'd2,
    PORTA = 2'd3
  } estado_t;

endpackage

// File: rtl/elevador_busca_andar.sv
// elevador_busca_andar: combinational search for the closest pending call
// strictly above and strictly below the car's current floor.
module elevador_busca_andar
  import elevador_pkg::*;
#(
  parameter int N_ANDARES = N_ANDARES_DEF
) (
  input  logic [N_ANDARES-1:0] pendentes,
  input  logic [FLOOR_W-1:0]   andar_atual,
  output logic [FLOOR_W-1:0]   nearest_up,
  output logic                 has_up,
  output logic [FLOOR_W-1:0]   nearest_down,
  output logic                 has_down
);

  // Scan down for "up" so the lowest floor above wins; scan up for "down" so the highest floor below wins.
  always_comb begin
    has_up       = 1'b0;
    nearest_up   = {FLOOR_W{1'b0}};
    has_down     = 1'b0;
    nearest_down = {FLOOR_W{1'b0}};
    for (int i = N_ANDARES - 1; i >= 0; i--) begin
      nearest_up = (pendentes[i] && (i > int'(andar_atual))) ? FLOOR_W'(i) : nearest_up;
      has_up     = has_up | (pendentes[i] && (i > int'(andar_atual)));
    end
    for (int i = 0; i < N_ANDARES; i++) begin
      nearest_down = (pendentes[i] && (i < int'(andar_atual))) ? FLOOR_W'(i) : nearest_down;
      has_down     = has_down | (pendentes[i] && (i < int'(andar_atual)));
    end
  end

endmodule

// File: rtl/elevador_escalonador.sv
// elevador_escalonador: LOOK-policy request scheduler for the elevador car.
// Latches floor calls, picks the next target floor, tracks the direction of
// travel and times the door-open dwell at each served floor.
// Optional feature macro: ELEV_DOOR_HOLD_EN (door_hold keeps the door open).
module elevador_escalonador
  import elevador_pkg::*;
#(
  parameter int N_ANDARES   = N_ANDARES_DEF,
  parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_ANDARES-1:0] req,
  input  logic [FLOOR_W-1:0]   andar_atual,
  input  logic                 parado,
  input  logic                 door_hold,
  output logic [FLOOR_W-1:0]   andar_requisitado,
  output logic                 alvo_valido,
  output logic                 porta_aberta,
  output logic                 direcao,
  output logic [N_ANDARES-1:0] pendentes
);

  localparam int                   TW         = $clog2(DOOR_CYCLES);
  localparam logic [TW-1:0]        TIMER_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [N_ANDARES-1:0] ONE_HOT0   = N_ANDARES'(1);

  estado_t              state_r;
  estado_t              state_nx;
  logic [TW-1:0]        timer_r;
  logic [TW-1:0]        timer_nx;
  logic [N_ANDARES-1:0] pend_nx;
  logic [N_ANDARES-1:0] floor_mask;
  logic [FLOOR_W-1:0]   nearest_up;
  logic [FLOOR_W-1:0]   nearest_down;
  logic [FLOOR_W-1:0]   alvo_nx;
  logic                 has_up;
  logic                 has_down;
  logic                 dir_nx;
  logic                 floor_ok;
  logic                 at_pend;
  logic                 door_req;
  logic                 hold;
  logic                 reload;
  logic                 arrived;

  elevador_busca_andar #(
    .N_ANDARES(N_ANDARES)
  ) u_busca (
    .pendentes   (pendentes),
    .andar_atual (andar_atual),
    .nearest_up  (nearest_up),
    .has_up      (has_up),
    .nearest_down(nearest_down),
    .has_down    (has_down)
  );

  // A floor report outside the building is treated as "no usable position".
  assign floor_ok   = (int'(andar_atual) < N_ANDARES);
  assign floor_mask = floor_ok ? (ONE_HOT0 << andar_atual) : {N_ANDARES{1'b0}};
  assign at_pend    = |(pendentes & floor_mask);
  assign door_req   = |(req & floor_mask);
  assign arrived    = parado && (andar_atual == andar_requisitado);

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  logic unused_door_hold;
  assign unused_door_hold = door_hold;
  assign hold             = 1'b0;
`endif

  // A call at the open floor, or a held door, restarts the dwell.
  assign reload = (state_r == PORTA) && (door_req || hold);

  // Next-state, target, direction and door timer selection.
  always_comb begin
    state_nx = state_r;
    timer_nx = timer_r;
    dir_nx   = direcao;
    alvo_nx  = andar_requisitado;
    if (!floor_ok) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (at_pend) begin
            state_nx = PORTA;
            timer_nx = TIMER_LOAD;
          end else if (has_up) begin
            state_nx = SOBE;
            dir_nx   = 1'b1;
            alvo_nx  = nearest_up;
          end else if (has_down) begin
            state_nx = DESCE;
            dir_nx   = 1'b0;
            alvo_nx  = nearest_down;
          end else begin
            state_nx = IDLE;
          end
        end
        SOBE: begin
          if (arrived) begin
            state_nx = PORTA;
            timer_nx = TIMER_LOAD;
          end else if (has_up) begin
            alvo_nx = nearest_up;
          end else begin
            state_nx = IDLE;
          end
        end
        DESCE: begin
          if (arrived) begin
            state_nx = PORTA;
            timer_nx = TIMER_LOAD;
          end else if (has_down) begin
            alvo_nx = nearest_down;
          end else begin
            state_nx = IDLE;
          end
        end
        PORTA: begin
          if (reload) begin
            timer_nx = TIMER_LOAD;
          end else if (timer_r != {TW{1'b0}}) begin
            timer_nx = timer_r - TW'(1);
          end else if (direcao && has_up) begin
            state_nx = SOBE;
            alvo_nx  = nearest_up;
          end else if (!direcao && has_down) begin
            state_nx = DESCE;
            alvo_nx  = nearest_down;
          end else if (has_up) begin
            state_nx = SOBE;
            dir_nx   = 1'b1;
            alvo_nx  = nearest_up;
          end else if (has_down) begin
            state_nx = DESCE;
            dir_nx   = 1'b0;
            alvo_nx  = nearest_down;
          end else begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Latch new calls; the served floor is cleared on entry and kept clear while the door is open.
  always_comb begin
    pend_nx = pendentes | req;
    if ((state_r == PORTA) || (state_nx == PORTA)) begin
      pend_nx = (pendentes | req) & ~floor_mask;
    end else begin
      pend_nx = pendentes | req;
    end
  end

  // State, timer, pending calls and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= IDLE;
      timer_r           <= {TW{1'b0}};
      pendentes         <= {N_ANDARES{1'b0}};
      andar_requisitado <= {FLOOR_W{1'b0}};
      alvo_valido       <= 1'b0;
      porta_aberta      <= 1'b0;
      direcao           <= 1'b0;
    end else begin
      state_r           <= state_nx;
      timer_r           <= timer_nx;
      pendentes         <= pend_nx;
      andar_requisitado <= alvo_nx;
      alvo_valido       <= (state_nx == SOBE) || (state_nx == DESCE);
      porta_aberta      <= (state_nx == PORTA);
      direcao           <= dir_nx;
    end
  end

endmodule

// File: tb/tb_elevador_escalonador.sv
// tb_elevador_escalonador: directed scenarios plus randomized calls, checked
// every cycle against a behavioural LOOK scheduler model.
module tb_elevador_escalonador;

  localparam int N    = 5;
  localparam int DOOR = 4;
`ifdef ELEV_DOOR_HOLD_EN
  localparam int HOLD_EXP = 14;
`else
  localparam int HOLD_EXP = 4;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [2:0]   andar_atual = 3'd0;
  logic         parado = 1'b1;
  logic         door_hold = 1'b0;
  logic [2:0]   andar_requisitado;
  logic         alvo_valido;
  logic         porta_aberta;
  logic         direcao;
  logic [N-1:0] pendentes;

  elevador_escalonador #(.N_ANDARES(N), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .reset(reset), .req(req), .andar_atual(andar_atual),
    .parado(parado), .door_hold(door_hold),
    .andar_requisitado(andar_requisitado), .alvo_valido(alvo_valido),
    .porta_aberta(porta_aberta), .direcao(direcao), .pendentes(pendentes));

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Environment: a car that moves one floor every move_t cycles toward the target.
  logic [2:0]   car_floor = 3'd0;
  int           move_cnt = 0;
  int           move_t = 3;
  logic [N-1:0] req_v = '0;
  logic         hold_v = 1'b0;
  logic [N-1:0] pulse_mask = '0;
  logic [2:0]   pulse_floor = 3'd0;
  int           bad_cnt = 0;

  // Reference model.
  typedef enum {M_PARADO, M_SUBINDO, M_DESCENDO, M_ABERTO} modo_t;
  modo_t        m_mode;
  logic [N-1:0] m_pend;
  logic [2:0]   m_target;
  logic         m_dir;
  int           m_dwell;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_PARADO; m_pend = '0; m_target = 3'd0; m_dir = 1'b0; m_dwell = 0;
  endtask

  task automatic go(input logic d, input int t);
    m_mode = d ? M_SUBINDO : M_DESCENDO;
    m_dir = d;
    m_target = 3'(t);
  endtask

  task automatic open_door();
    m_mode = M_ABERTO;
    m_dwell = DOOR;
  endtask

  // One clock edge of the scheduler rules, using the inputs present at that edge.
  task automatic model_step();
    int f; bit ok; int up; int dn; bit hold_eff; bit was_open; logic [N-1:0] nxt;
    f = int'(andar_atual);
    ok = (f < N);
    up = -1; dn = -1;
    for (int i = 0; i < N; i++) if (m_pend[i] && i > f && up < 0) up = i;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && i < f && dn < 0) dn = i;
`ifdef ELEV_DOOR_HOLD_EN
    hold_eff = door_hold;
`else
    hold_eff = 1'b0;
`endif
    was_open = (m_mode == M_ABERTO);
    nxt = m_pend | req;
    if (!ok) begin
      m_mode = M_PARADO;
    end else begin
      case (m_mode)
        M_PARADO: begin
          if (m_pend[f]) open_door();
          else if (up >= 0) go(1'b1, up);
          else if (dn >= 0) go(1'b0, dn);
        end
        M_SUBINDO: begin
          if (parado && f == int'(m_target)) open_door();
          else if (up >= 0) m_target = 3'(up);
          else m_mode = M_PARADO;
        end
        M_DESCENDO: begin
          if (parado && f == int'(m_target)) open_door();
          else if (dn >= 0) m_target = 3'(dn);
          else m_mode = M_PARADO;
        end
        M_ABERTO: begin
          if (req[f] || hold_eff) m_dwell = DOOR;
          else if (m_dwell > 1) m_dwell--;
          else if (m_dir && up >= 0) go(1'b1, up);
          else if (!m_dir && dn >= 0) go(1'b0, dn);
          else if (up >= 0) go(1'b1, up);
          else if (dn >= 0) go(1'b0, dn);
          else m_mode = M_PARADO;
        end
        default: m_mode = M_PARADO;
      endcase
      if (was_open || m_mode == M_ABERTO) nxt[f] = 1'b0;
    end
    m_pend = nxt;
  endtask

  task automatic compare_all();
    check_eq("target", andar_requisitado, m_target);
    check_eq("valid", alvo_valido, (m_mode == M_SUBINDO) || (m_mode == M_DESCENDO));
    check_eq("door", porta_aberta, m_mode == M_ABERTO);
    check_eq("dir", direcao, m_dir);
    check_eq("pend", pendentes, m_pend);
  endtask

  // Drive one cycle at the falling edge, then step and compare just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (alvo_valido && (car_floor != andar_requisitado)) begin
      move_cnt++;
      if (move_cnt >= move_t) begin
        car_floor = (andar_requisitado > car_floor) ? car_floor + 3'd1 : car_floor - 3'd1;
        move_cnt = 0;
      end
    end else begin
      move_cnt = 0;
    end
    parado = !(alvo_valido && (car_floor != andar_requisitado));
    req = req_v;
    if (pulse_mask != '0 && car_floor == pulse_floor) begin
      req = req_v | pulse_mask;
      pulse_mask = '0;
    end
    door_hold = hold_v;
    if (bad_cnt > 0) begin
      andar_atual = 3'(5 + $urandom_range(0, 2));
      bad_cnt--;
    end else begin
      andar_atual = car_floor;
    end
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic wait_door(input int budget);
    int k = 0;
    while (!porta_aberta && k < budget) begin
      cycle();
      k++;
    end
    check_eq("door_timeout", porta_aberta, 1'b1);
  endtask

  // Count door-open samples; optionally pulse a call or hold the door along the way.
  task automatic door_dwell(input logic [N-1:0] pmask, input int pat, input int hold_n, output int n);
    n = 1;
    while (porta_aberta && n < 60) begin
      req_v = (n == pat) ? pmask : '0;
      hold_v = (n <= hold_n);
      cycle();
      if (porta_aberta) n++;
    end
    req_v = '0;
    hold_v = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_target", andar_requisitado, 3'd0);
    check_eq("rst_valid", alvo_valido, 1'b0);
    check_eq("rst_door", porta_aberta, 1'b0);
    check_eq("rst_dir", direcao, 1'b0);
    check_eq("rst_pend", pendentes, 5'b00000);
    reset = 1'b0;

    // Scenario 1: call to floor 4 from floor 0.
    car_floor = 3'd0;
    req_v = 5'b10000;
    cycle();
    check_eq("s1_pend", pendentes, 5'b10000);
    req_v = '0;
    cycle();
    check_eq("s1_target", andar_requisitado, 3'd4);
    check_eq("s1_valid", alvo_valido, 1'b1);
    check_eq("s1_dir", direcao, 1'b1);

    // Scenario 2: a call at floor 2 made while passing floor 1 preempts.
    pulse_floor = 3'd1;
    pulse_mask = 5'b00100;
    wait_door(100);
    check_eq("s2_floor", car_floor, 3'd2);
    check_eq("s2_pend2", pendentes[2], 1'b0);
    door_dwell('0, -1, 0, n);
    check_eq("s2_dwell", n, DOOR);
    check_eq("s2_target", andar_requisitado, 3'd4);
    check_eq("s2_valid", alvo_valido, 1'b1);

    // Scenario 3: calls below made while the door is open at floor 4.
    wait_door(100);
    check_eq("s3_floor4", car_floor, 3'd4);
    door_dwell(5'b01001, 1, 0, n);
    check_eq("s3_dwell4", n, DOOR);
    check_eq("s3_dir", direcao, 1'b0);
    check_eq("s3_target3", andar_requisitado, 3'd3);
    wait_door(100);
    check_eq("s3_floor3", car_floor, 3'd3);
    door_dwell('0, -1, 0, n);
    check_eq("s3_target0", andar_requisitado, 3'd0);
    wait_door(100);
    check_eq("s3_floor0", car_floor, 3'd0);
    door_dwell('0, -1, 0, n);

    // Scenario 4: call at the idle floor, re-called during the dwell.
    car_floor = 3'd2;
    cycle();
    cycle();
    req_v = 5'b00100;
    cycle();
    req_v = '0;
    cycle();
    check_eq("s4_door", porta_aberta, 1'b1);
    check_eq("s4_valid", alvo_valido, 1'b0);
    door_dwell(5'b00100, 2, 0, n);
    check_eq("s4_dwell", n, DOOR + 2);
    check_eq("s4_pend", pendentes, 5'b00000);

    // Scenario 6: door_hold high for 10 cycles.
    req_v = 5'b00100;
    cycle();
    req_v = '0;
    cycle();
    check_eq("s6_door", porta_aberta, 1'b1);
    door_dwell('0, -1, 10, n);
    check_eq("s6_dwell", n, HOLD_EXP);

    // Scenario 5: asynchronous reset while travelling up.
    req_v = 5'b10000;
    cycle();
    req_v = '0;
    k = 0;
    while (!alvo_valido && k < 10) begin
      cycle();
      k++;
    end
    check_eq("s5_moving", alvo_valido, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("s5_target", andar_requisitado, 3'd0);
    check_eq("s5_valid", alvo_valido, 1'b0);
    check_eq("s5_door", porta_aberta, 1'b0);
    check_eq("s5_dir", direcao, 1'b0);
    check_eq("s5_pend", pendentes, 5'b00000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle();
    check_eq("s5_idle", alvo_valido, 1'b0);

    // Randomized calls, door holds, travel speeds and out-of-range floor reports.
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) move_t = $urandom_range(1, 3);
      req_v = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      hold_v = ($urandom_range(0, 5) == 0);
      if (bad_cnt == 0 && $urandom_range(0, 199) == 0) bad_cnt = $urandom_range(1, 3);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
